// File: rtl/tick_gen_pkg.sv
// ---------------------------------------------------------------------------
// tick_gen_pkg
// Purpose : Shared definitions for the tick generator. Holds the controller
//           state encoding and the default width of the divide-ratio path.
// Contents:
//   DIV_W_DEF - default width of the divide ratio and prescale counter
//   state_t   - controller states IDLE / RUN / ONESHOT
// ---------------------------------------------------------------------------
package tick_gen_pkg;

    localparam int DIV_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        ONESHOT = 2'd2
    } state_t;

endpackage : tick_gen_pkg

// File: rtl/tick_div_cnt.sv
// ---------------------------------------------------------------------------
// tick_div_cnt
// Purpose : Reloadable prescale down-counter used by tick_gen. It holds at
//           zero rather than wrapping; the owner reloads it when it needs a
//           new period.
// Ports   :
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset, clears the count
//   i_load     in   load i_load_val this edge (wins over i_dec)
//   i_load_val in   DIV_W value to load
//   i_dec      in   decrement by one this edge (ignored at zero)
//   o_zero     out  count is zero
// ---------------------------------------------------------------------------
module tick_div_cnt
    import tick_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            // Zero is a floor: the count only returns to the top via a load.
            r_count <= r_count - ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : tick_div_cnt

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Purpose : Programmable tick generator. Emits a one-cycle registered pulse
//           every div_q cycles while running (RUN), or exactly once (ONESHOT).
//           The first tick lands div_q edges after the accepting edge.
// Build option:
//   TICK_GEN_BURST_EN - when defined, adds burst_len/done; RUN stops by itself
//                       after burst_len ticks (burst_len = 0 runs forever).
// Ports   :
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin (or restart) continuous ticking
//   single     in   request one tick
//   stop       in   abort activity, highest priority
//   div        in   DIV_W divide ratio, 0 treated as 1, sampled only on accept
//   burst_len  in   DIV_W tick count per run (TICK_GEN_BURST_EN only)
//   done       out  pulses with the final tick of a burst (TICK_GEN_BURST_EN only)
//   tick       out  one-cycle registered tick pulse
//   busy       out  registered, high in RUN or ONESHOT
// ---------------------------------------------------------------------------
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             single,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
`ifdef TICK_GEN_BURST_EN
    input  logic [DIV_W-1:0] burst_len,
    output logic             done,
`endif
    output logic             tick,
    output logic             busy
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    state_t           r_state;
    logic             r_tick;
    logic             r_busy;
    logic [DIV_W-1:0] r_div_q;

    logic [DIV_W-1:0] w_div_in;
    logic [DIV_W-1:0] w_load_val;
    logic             w_accept;
    logic             w_reload;
    logic             w_load;
    logic             w_dec;
    logic             w_zero;

`ifdef TICK_GEN_BURST_EN
    logic [DIV_W-1:0] r_burst_len;
    logic [DIV_W-1:0] r_burst_cnt;
    logic             r_done;
`endif

    // A ratio of zero would never tick; run it as divide-by-one instead.
    assign w_div_in = (div == '0) ? ONE : div;

    // Edges that (re)latch div and restart the phase: a fresh start/single
    // from IDLE, or a restart while running.
    assign w_accept = !stop && (((r_state == IDLE) && (start || single)) ||
                                ((r_state == RUN) && start));

    // Reload after the tick edge so the next tick is a full period later.
    assign w_reload = (r_state == RUN) && !stop && !start && w_zero;

    assign w_load     = w_accept || w_reload;
    assign w_load_val = w_accept ? (w_div_in - ONE) : (r_div_q - ONE);
    assign w_dec      = ((r_state == RUN) || (r_state == ONESHOT)) && !stop &&
                        !w_accept && !w_zero;

    tick_div_cnt #(
        .DIV_W (DIV_W)
    ) u_div_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
            r_div_q <= '0;
`ifdef TICK_GEN_BURST_EN
            r_burst_len <= '0;
            r_burst_cnt <= '0;
            r_done      <= 1'b0;
`endif
        end else begin
            r_tick <= 1'b0;
`ifdef TICK_GEN_BURST_EN
            r_done <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!stop && (start || single)) begin
                        r_div_q <= w_div_in;
                        r_busy  <= 1'b1;
                        r_state <= start ? RUN : ONESHOT;
`ifdef TICK_GEN_BURST_EN
                        r_burst_len <= burst_len;
                        r_burst_cnt <= '0;
`endif
                    end
                end

                RUN: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (start) begin
                        // Restart: new ratio, new phase, no tick this edge.
                        r_div_q <= w_div_in;
`ifdef TICK_GEN_BURST_EN
                        r_burst_len <= burst_len;
                        r_burst_cnt <= '0;
`endif
                    end else if (w_zero) begin
                        r_tick <= 1'b1;
`ifdef TICK_GEN_BURST_EN
                        if (r_burst_len != '0) begin
                            if (r_burst_cnt == (r_burst_len - ONE)) begin
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_burst_cnt <= r_burst_cnt + ONE;
                            end
                        end
`endif
                    end
                end

                ONESHOT: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_zero) begin
                        // The single tick and the return to IDLE share an edge.
                        r_tick  <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tick = r_tick;
    assign busy = r_busy;
`ifdef TICK_GEN_BURST_EN
    assign done = r_done;
`endif

endmodule : tick_gen

// File: tb/tb_tick_gen.sv
module tb_tick_gen;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             single;
    logic             stop;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             busy;
`ifdef TICK_GEN_BURST_EN
    logic [DIV_W-1:0] burst_len;
    logic             done;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: event schedule in absolute edge numbers.
    int   n        = 0;   // edge counter
    int   m_mode   = 0;   // 0 idle, 1 continuous, 2 one-shot
    int   m_period = 0;
    int   m_next   = 0;   // edge at which the next tick is due
    int   m_blen   = 0;
    int   m_bcnt   = 0;
    logic e_tick   = 1'b0;
    logic e_busy   = 1'b0;
    logic e_done   = 1'b0;
    int   ticks_seen = 0;

    tick_gen #(
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .single    (single),
        .stop      (stop),
        .div       (div),
`ifdef TICK_GEN_BURST_EN
        .burst_len (burst_len),
        .done      (done),
`endif
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        int d;
        e_tick = 1'b0;
        e_done = 1'b0;
        d = (div == 0) ? 1 : int'(div);
        if (reset) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (!stop && (start || single)) begin
                    m_mode   = start ? 1 : 2;
                    m_period = d;
                    m_next   = n + d;
                    m_bcnt   = 0;
`ifdef TICK_GEN_BURST_EN
                    m_blen   = int'(burst_len);
`endif
                end
                1: if (stop) begin
                    m_mode = 0;
                end else if (start) begin
                    m_period = d;
                    m_next   = n + d;
                    m_bcnt   = 0;
`ifdef TICK_GEN_BURST_EN
                    m_blen   = int'(burst_len);
`endif
                end else if (n == m_next) begin
                    e_tick = 1'b1;
                    m_next = n + m_period;
`ifdef TICK_GEN_BURST_EN
                    m_bcnt = m_bcnt + 1;
                    if (m_blen != 0 && m_bcnt == m_blen) begin
                        e_done = 1'b1;
                        m_mode = 0;
                    end
`endif
                end
                default: if (stop) begin
                    m_mode = 0;
                end else if (n == m_next) begin
                    e_tick = 1'b1;
                    m_mode = 0;
                end
            endcase
        end
        e_busy = (m_mode != 0);
    endtask

    // Apply inputs for one edge, advance the model, then compare outputs.
    task automatic cyc(input logic rs, input logic st, input logic sg,
                       input logic sp, input logic [DIV_W-1:0] d);
        reset  = rs;
        start  = st;
        single = sg;
        stop   = sp;
        div    = d;
        @(posedge clk);
        n = n + 1;
        model_edge();
        #1;
        if (tick === 1'b1) ticks_seen = ticks_seen + 1;
        checks = checks + 1;
        assert (tick === e_tick) else begin
            errors = errors + 1;
            $error("FAIL tick edge=%0d: observed=%b expected=%b", n, tick, e_tick);
        end
        checks = checks + 1;
        assert (busy === e_busy) else begin
            errors = errors + 1;
            $error("FAIL busy edge=%0d: observed=%b expected=%b", n, busy, e_busy);
        end
`ifdef TICK_GEN_BURST_EN
        checks = checks + 1;
        assert (done === e_done) else begin
            errors = errors + 1;
            $error("FAIL done edge=%0d: observed=%b expected=%b", n, done, e_done);
        end
`endif
    endtask

    task automatic chk_count(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs == exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        single = 1'b0;
        stop   = 1'b0;
        div    = '0;
`ifdef TICK_GEN_BURST_EN
        burst_len = '0;
`endif
        // Reset state
        cyc(1, 0, 0, 0, 8'd0);
        cyc(1, 1, 1, 0, 8'd4);

        // div=4 start on the first edge after reset: ticks at +4,+8,+12;
        // div input changes while running are ignored.
        ticks_seen = 0;
        cyc(0, 1, 0, 0, 8'd4);
        repeat (13) cyc(0, 0, 0, 0, 8'd2);
        chk_count("div4_tick_count", ticks_seen, 3);
        cyc(0, 0, 0, 1, 8'd0);
        repeat (3) cyc(0, 0, 0, 0, 8'd0);

        // div=0 behaves as divide-by-one
        ticks_seen = 0;
        cyc(0, 1, 0, 0, 8'd0);
        repeat (5) cyc(0, 0, 0, 0, 8'd0);
        chk_count("div0_every_cycle", ticks_seen, 5);
        cyc(0, 0, 0, 1, 8'd0);
        repeat (2) cyc(0, 0, 0, 0, 8'd0);

        // single with div=3: one tick, then idle
        ticks_seen = 0;
        cyc(0, 0, 1, 0, 8'd3);
        repeat (8) cyc(0, 0, 0, 0, 8'd3);
        chk_count("single_div3", ticks_seen, 1);

        // start/single ignored while in ONESHOT
        ticks_seen = 0;
        cyc(0, 0, 1, 0, 8'd6);
        cyc(0, 1, 0, 0, 8'd1);
        cyc(0, 0, 1, 0, 8'd1);
        repeat (8) cyc(0, 0, 0, 0, 8'd1);
        chk_count("oneshot_ignores_start", ticks_seen, 1);

        // div=5 running, start+stop together at cycle 7
        cyc(0, 1, 0, 0, 8'd5);
        repeat (6) cyc(0, 0, 0, 0, 8'd5);
        cyc(0, 1, 0, 1, 8'd5);
        ticks_seen = 0;
        repeat (10) cyc(0, 0, 0, 0, 8'd5);
        chk_count("stop_beats_start", ticks_seen, 0);

        // reset mid-run with count at 2
        cyc(0, 1, 0, 0, 8'd5);
        repeat (2) cyc(0, 0, 0, 0, 8'd5);
        cyc(1, 0, 0, 0, 8'd5);
        ticks_seen = 0;
        repeat (10) cyc(0, 0, 0, 0, 8'd5);
        chk_count("reset_mid_run", ticks_seen, 0);

        // restart in RUN resets phase; single in RUN ignored
        cyc(0, 1, 0, 0, 8'd3);
        repeat (2) cyc(0, 0, 0, 0, 8'd3);
        ticks_seen = 0;
        cyc(0, 1, 0, 0, 8'd4);
        cyc(0, 0, 1, 0, 8'd1);
        repeat (3) cyc(0, 0, 0, 0, 8'd1);
        chk_count("restart_phase", ticks_seen, 1);
        cyc(0, 0, 0, 1, 8'd0);

`ifdef TICK_GEN_BURST_EN
        // burst of 3 at div=2: ticks at +2,+4,+6, done with the last
        burst_len  = 8'd3;
        ticks_seen = 0;
        cyc(0, 1, 0, 0, 8'd2);
        burst_len  = 8'd0;
        repeat (10) cyc(0, 0, 0, 0, 8'd2);
        chk_count("burst3_ticks", ticks_seen, 3);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
`ifdef TICK_GEN_BURST_EN
            burst_len = DIV_W'($urandom_range(0, 4));
`endif
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 15) == 0),
                DIV_W'($urandom_range(0, 6)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tick_gen
